// File: rtl/datapath_pkg.sv
// datapath_pkg
//   Shared datapath definitions for the decode and execute/writeback stages.
//   DATA_W   : register/operand width.
//   alu_op_e : 3-bit ALU operation encoding carried in ALUOp2.
package datapath_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_MOV  = 3'b000,
    ALU_NOT  = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_AND  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu32.sv
// alu32
//   Purely combinational 32-bit ALU.
//   a, b : operands (DATA_W)
//   op   : operation (alu_op_e)
//   y    : result (DATA_W); ADD/SUB wrap, SLT/SLTU return 0 or 1.
module alu32
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_MOV:  y = a;
      ALU_NOT:  y = ~a;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/exec_writeback_stage.sv
// exec_writeback_stage
//   Stage 3 of the pipeline: runs the ALU on the stage-2 operand bundle and
//   registers the result as the register-file write port. Also provides the
//   forwarding path back to decode and a count of retired register writes.
//   Inputs : clk, rst (sync, active-high), s2_valid, stall, flush,
//            S2_RD1/S2_RD2/Imm2, Data_S2 (B = Imm2 when 1), ALUOp2,
//            S2_WriteEnable/S2_WriteSelect, src1_sel/src2_sel (decode sources).
//   Outputs: S3_ALUOut/S3_WriteEnable/S3_WriteSelect/S3_valid (write port),
//            fwd_hit1/fwd_hit2/fwd_data (forwarding), retire_count.
module exec_writeback_stage
  import datapath_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s2_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] S2_RD1,
  input  logic [DATA_W-1:0] S2_RD2,
  input  logic [DATA_W-1:0] Imm2,
  input  logic              Data_S2,
  input  logic [2:0]        ALUOp2,
  input  logic              S2_WriteEnable,
  input  logic [4:0]        S2_WriteSelect,
  input  logic [4:0]        src1_sel,
  input  logic [4:0]        src2_sel,
  output logic [DATA_W-1:0] S3_ALUOut,
  output logic              S3_WriteEnable,
  output logic [4:0]        S3_WriteSelect,
  output logic              S3_valid,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              load_we;

  logic [DATA_W-1:0] alu_out_d, alu_out_q;
  logic              we_d, we_q;
  logic [4:0]        ws_d, ws_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  retire_d, retire_q;

  assign alu_b = Data_S2 ? Imm2 : S2_RD2;

  alu32 u_alu (
    .a  (S2_RD1),
    .b  (alu_b),
    .op (alu_op_e'(ALUOp2)),
    .y  (alu_y)
  );

  // Register 0 is hardwired, so a write to it is never enabled or counted.
  assign load_we = s2_valid & S2_WriteEnable & (S2_WriteSelect != 5'd0);

  // Priority: rst > flush > stall > load.
  always_comb begin
    alu_out_d = alu_out_q;
    we_d      = we_q;
    ws_d      = ws_q;
    valid_d   = valid_q;
    retire_d  = retire_q;
    if (rst) begin
      alu_out_d = '0;
      we_d      = 1'b0;
      ws_d      = '0;
      valid_d   = 1'b0;
      retire_d  = '0;
    end else if (flush) begin
      alu_out_d = '0;
      we_d      = 1'b0;
      ws_d      = '0;
      valid_d   = 1'b0;
    end else if (!stall) begin
      alu_out_d = alu_y;
      we_d      = load_we;
      ws_d      = S2_WriteSelect;
      valid_d   = s2_valid;
      if (load_we) retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    alu_out_q <= alu_out_d;
    we_q      <= we_d;
    ws_q      <= ws_d;
    valid_q   <= valid_d;
    retire_q  <= retire_d;
  end

  assign S3_ALUOut      = alu_out_q;
  assign S3_WriteEnable = we_q;
  assign S3_WriteSelect = ws_q;
  assign S3_valid       = valid_q;
  assign retire_count   = retire_q;

  // Forwarding compares the registered S3 destination against decode's
  // sources in the same cycle, so a dependent consumer needs no bubble.
  assign fwd_hit1 = valid_q & we_q & (ws_q == src1_sel) & (src1_sel != 5'd0);
  assign fwd_hit2 = valid_q & we_q & (ws_q == src2_sel) & (src2_sel != 5'd0);
  assign fwd_data = alu_out_q;

endmodule

// File: tb/tb_exec_writeback_stage.sv
module tb_exec_writeback_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst, s2_valid, stall, flush, Data_S2, S2_WriteEnable;
  logic [31:0] S2_RD1, S2_RD2, Imm2;
  logic [2:0]  ALUOp2;
  logic [4:0]  S2_WriteSelect, src1_sel, src2_sel;
  logic [31:0] S3_ALUOut, fwd_data;
  logic        S3_WriteEnable, S3_valid, fwd_hit1, fwd_hit2;
  logic [4:0]  S3_WriteSelect;
  logic [CW-1:0] retire_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exec_writeback_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s2_valid(s2_valid), .stall(stall), .flush(flush),
    .S2_RD1(S2_RD1), .S2_RD2(S2_RD2), .Imm2(Imm2), .Data_S2(Data_S2),
    .ALUOp2(ALUOp2), .S2_WriteEnable(S2_WriteEnable),
    .S2_WriteSelect(S2_WriteSelect), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .S3_ALUOut(S3_ALUOut), .S3_WriteEnable(S3_WriteEnable),
    .S3_WriteSelect(S3_WriteSelect), .S3_valid(S3_valid),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  typedef struct packed {
    logic        rst, valid, stall, flush;
    logic [31:0] rd1, rd2, imm;
    logic        ds;
    logic [2:0]  op;
    logic        we;
    logic [4:0]  ws, s1, s2;
    logic [31:0] e_out;
    logic        e_we;
    logic [4:0]  e_ws;
    logic        e_v;
    logic [3:0]  e_cnt;
    logic        e_h1, e_h2;
  } vec_t;

  function automatic vec_t mkv(
    logic r, logic v, logic st, logic fl, logic [31:0] a, logic [31:0] b,
    logic [31:0] im, logic ds, logic [2:0] op, logic we, logic [4:0] ws,
    logic [4:0] s1, logic [4:0] s2, logic [31:0] eo, logic ewe,
    logic [4:0] ews, logic ev, logic [3:0] ec, logic eh1, logic eh2);
    vec_t t;
    t.rst = r; t.valid = v; t.stall = st; t.flush = fl;
    t.rd1 = a; t.rd2 = b; t.imm = im; t.ds = ds; t.op = op; t.we = we;
    t.ws = ws; t.s1 = s1; t.s2 = s2;
    t.e_out = eo; t.e_we = ewe; t.e_ws = ews; t.e_v = ev; t.e_cnt = ec;
    t.e_h1 = eh1; t.e_h2 = eh2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic st, input logic fl,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic ds, input logic [2:0] op, input logic we,
                       input logic [4:0] ws);
    rst = r; s2_valid = v; stall = st; flush = fl; S2_RD1 = a; S2_RD2 = b;
    Imm2 = im; Data_S2 = ds; ALUOp2 = op; S2_WriteEnable = we; S2_WriteSelect = ws;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] eo, input logic ewe,
                           input logic [4:0] ews, input logic ev, input logic [3:0] ec);
    chk({tag, ".out"},   S3_ALUOut, eo);
    chk({tag, ".we"},    {31'b0, S3_WriteEnable}, {31'b0, ewe});
    chk({tag, ".ws"},    {27'b0, S3_WriteSelect}, {27'b0, ews});
    chk({tag, ".valid"}, {31'b0, S3_valid}, {31'b0, ev});
    chk({tag, ".cnt"},   {28'b0, retire_count}, {28'b0, ec});
    chk({tag, ".fdata"}, fwd_data, eo);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mkv(1,1,0,0, 32'd9,32'd9,32'd0,0,3'b010,1,5'd3, 5'd3,5'd3,  32'h0,0,5'd0,0,4'd0,0,0);
    vecs[1]  = mkv(0,1,0,0, 32'd5,32'd99,32'd7,1,3'b010,1,5'd3, 5'd3,5'd5,  32'd12,1,5'd3,1,4'd1,1,0);
    vecs[2]  = mkv(0,1,0,0, 32'd0,32'd1,32'd0,0,3'b011,1,5'd5, 5'd5,5'd0,  32'hFFFFFFFF,1,5'd5,1,4'd2,1,0);
    vecs[3]  = mkv(0,1,0,0, 32'hFFFFFFFF,32'd1,32'd0,0,3'b110,1,5'd6, 5'd1,5'd6, 32'd1,1,5'd6,1,4'd3,0,1);
    vecs[4]  = mkv(0,1,0,0, 32'hFFFFFFFF,32'd1,32'd0,0,3'b111,1,5'd7, 5'd7,5'd7, 32'd0,1,5'd7,1,4'd4,1,1);
    vecs[5]  = mkv(0,1,0,0, 32'd1,32'd2,32'd0,0,3'b010,1,5'd0, 5'd0,5'd0,  32'd3,0,5'd0,1,4'd4,0,0);
    vecs[6]  = mkv(0,1,0,0, 32'hAAAA5555,32'd0,32'd0,0,3'b000,1,5'd4, 5'd4,5'd4, 32'hAAAA5555,1,5'd4,1,4'd5,1,1);
    vecs[7]  = mkv(0,1,0,0, 32'h0F0F0F0F,32'd0,32'd0,0,3'b001,1,5'd8, 5'd0,5'd8, 32'hF0F0F0F0,1,5'd8,1,4'd6,0,1);
    vecs[8]  = mkv(0,1,0,0, 32'hF0,32'h0F,32'd0,0,3'b100,1,5'd9, 5'd9,5'd1,  32'hFF,1,5'd9,1,4'd7,1,0);
    vecs[9]  = mkv(0,1,0,0, 32'hFF00,32'h0FF0,32'd0,0,3'b101,1,5'd10, 5'd10,5'd10, 32'h0F00,1,5'd10,1,4'd8,1,1);
    vecs[10] = mkv(0,1,0,0, 32'hFFFFFFFF,32'd0,32'd2,1,3'b010,1,5'd11, 5'd11,5'd0, 32'd1,1,5'd11,1,4'd9,1,0);
    vecs[11] = mkv(0,0,0,0, 32'd1,32'd1,32'd0,0,3'b010,1,5'd12, 5'd12,5'd12, 32'd2,0,5'd12,0,4'd9,0,0);
    vecs[12] = mkv(0,1,0,0, 32'd7,32'd0,32'd0,0,3'b000,0,5'd13, 5'd13,5'd13, 32'd7,0,5'd13,1,4'd9,0,0);

    drive(1,0,0,0,0,0,0,0,3'b000,0,5'd0);
    src1_sel = 5'd0; src2_sel = 5'd0;
    repeat (2) step();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].stall, vecs[i].flush, vecs[i].rd1,
            vecs[i].rd2, vecs[i].imm, vecs[i].ds, vecs[i].op, vecs[i].we, vecs[i].ws);
      src1_sel = vecs[i].s1; src2_sel = vecs[i].s2;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_we, vecs[i].e_ws,
                vecs[i].e_v, vecs[i].e_cnt);
      chk($sformatf("vec%0d.hit1", i), {31'b0, fwd_hit1}, {31'b0, vecs[i].e_h1});
      chk($sformatf("vec%0d.hit2", i), {31'b0, fwd_hit2}, {31'b0, vecs[i].e_h2});
    end

    // Stall: load a write to r4, then hold 3 cycles while inputs change.
    drive(0,1,0,0,32'h1234,0,0,0,3'b000,1,5'd4);
    step();
    chk_state("pre_stall", 32'h1234, 1, 5'd4, 1, 4'd10);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,1,0,32'h100 + i,32'h5,32'h9,i[0],3'(i+2),1,5'(20+i));
      src1_sel = 5'd4; src2_sel = 5'd4;
      step();
      chk_state($sformatf("stall%0d", i), 32'h1234, 1, 5'd4, 1, 4'd10);
      chk($sformatf("stall%0d.hit1", i), {31'b0, fwd_hit1}, 32'd1);
      chk($sformatf("stall%0d.hit2", i), {31'b0, fwd_hit2}, 32'd1);
    end
    src1_sel = 5'd0;
    #1 chk("src0.hit1", {31'b0, fwd_hit1}, 32'd0);

    // Stall together with flush performs the flush.
    drive(0,1,1,1,32'h55,0,0,0,3'b000,1,5'd6);
    step();
    chk_state("stall_flush", 32'h0, 0, 5'd0, 0, 4'd10);

    // Flush alone kills a valid write.
    drive(0,1,0,1,32'h66,0,0,0,3'b000,1,5'd7);
    step();
    chk_state("flush", 32'h0, 0, 5'd0, 0, 4'd10);

    // Counter wrap: 16 retiring writes from reset return the count to 0.
    drive(1,0,0,0,0,0,0,0,3'b000,0,5'd0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(0,1,0,0,32'(i),0,0,0,3'b000,1,5'd1);
      step();
      if (i == 14) chk("wrap15.cnt", {28'b0, retire_count}, 32'd15);
    end
    chk("wrap16.cnt", {28'b0, retire_count}, 32'd0);
    chk("wrap16.out", S3_ALUOut, 32'd15);

    // Reset alongside a valid write discards it without counting.
    drive(0,1,0,0,32'h77,0,0,0,3'b000,1,5'd2);
    step();
    chk("pre_rst.cnt", {28'b0, retire_count}, 32'd1);
    drive(1,1,0,0,32'h88,0,0,0,3'b000,1,5'd2);
    src1_sel = 5'd2; src2_sel = 5'd2;
    step();
    chk_state("rst_mid", 32'h0, 0, 5'd0, 0, 4'd0);
    chk("rst_mid.hit1", {31'b0, fwd_hit1}, 32'd0);
    chk("rst_mid.hit2", {31'b0, fwd_hit2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_writeback_stage.md
EXEC_WRITEBACK_STAGE -- requirements
Module: exec_writeback_stage

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retire counter.
REQ-002 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port s2_valid, input, 1, the stage-2 operand bundle is a real instruction.
REQ-005 The block SHALL have port stall, input, 1, hold all stage-3 state.
REQ-006 The block SHALL have port flush, input, 1, kill the incoming bundle.
REQ-007 The block SHALL have ports S2_RD1/S2_RD2, input, 32 each, latched register operands.
REQ-008 The block SHALL have ports Imm2 (input, 32, immediate), Data_S2 (input, 1, 1 = operand B is Imm2, 0 = S2_RD2) and ALUOp2 (input, 3, operation).
REQ-009 The block SHALL have ports S2_WriteEnable (input, 1) and S2_WriteSelect (input, 5), the destination control.
REQ-010 The block SHALL have ports src1_sel/src2_sel, input, 5 each, source register numbers of the instruction now in decode.
REQ-011 The block SHALL have outputs S3_ALUOut (32), S3_WriteEnable (1), S3_WriteSelect (5) and S3_valid (1), forming the registered register-file write port.
REQ-012 The block SHALL have outputs fwd_hit1/fwd_hit2 (1 each) and fwd_data (32), the forwarding path to decode.
REQ-013 The block SHALL have output retire_count, CNT_W bits, the count of retired register writes.

Function
REQ-014 The ALU SHALL compute A = S2_RD1 and B = Data_S2 ? Imm2 : S2_RD2.
REQ-015 The ALU result SHALL be selected by ALUOp2 as follows: 000 A; 001 ~A; 010 A+B; 011 A-B; 100 A|B; 101 A&B; 110 signed A<B ? 1 : 0; 111 unsigned A<B ? 1 : 0.
REQ-016 ADD and SUB SHALL wrap modulo 2^32; no overflow flag is produced.
REQ-017 Priority at each clock edge SHALL be rst > flush > stall > load.
REQ-018 On load, S3_ALUOut, S3_WriteSelect and S3_valid SHALL take the ALU result, S2_WriteSelect and s2_valid respectively, giving a latency of exactly 1 cycle.
REQ-019 On load, S3_WriteEnable SHALL take s2_valid & S2_WriteEnable & (S2_WriteSelect != 0), so register 0 is never written.
REQ-020 On flush, S3_valid and S3_WriteEnable SHALL become 0, and S3_ALUOut and S3_WriteSelect SHALL become 0.
REQ-021 Flush asserted together with stall SHALL perform the flush.
REQ-022 On stall without flush, all registered outputs and retire_count SHALL hold their values.
REQ-023 fwd_hit1 SHALL be combinational and equal S3_valid & S3_WriteEnable & (S3_WriteSelect == src1_sel) & (src1_sel != 0); fwd_hit2 SHALL be the same using src2_sel.
REQ-024 fwd_data SHALL always equal S3_ALUOut.
REQ-025 retire_count SHALL increment by 1 on each load whose computed S3_WriteEnable value is 1, and SHALL wrap from all-ones to 0.
REQ-026 A back-to-back dependent pair (producer in S3, consumer in decode) SHALL be served by forwarding with no bubble.

Reset
REQ-027 While rst is high at a clock edge, S3_ALUOut, S3_WriteSelect and retire_count SHALL become 0.
REQ-028 While rst is high at a clock edge, S3_WriteEnable and S3_valid SHALL become 0.
REQ-029 rst SHALL override stall and flush; asserting rst mid-stream SHALL discard the in-flight bundle without counting it.
REQ-030 In the first cycle after reset, fwd_hit1 and fwd_hit2 SHALL be 0.

Structure
REQ-031 The ALUOp encodings (ALU_MOV, ALU_NOT, ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU) and the 32-bit data width constant SHALL be defined in the shared package datapath_pkg, which the decode stage also uses.
REQ-032 The combinational ALU SHALL be a sub-module named alu32 (inputs a, b, op; output y).
REQ-033 Forwarding comparators and the retire counter SHALL be implemented in this module.

Verification
REQ-034 The bench SHALL cover: reset, then s2_valid=1, ALUOp2=010, RD1=5, Data_S2=1, Imm2=7, WE=1, WS=3 -> next cycle S3_ALUOut=12, WS=3, WE=1, retire_count=1.
REQ-035 The bench SHALL cover: ALUOp2=011, RD1=0, RD2=1 -> 0xFFFFFFFF; ALUOp2=110 with RD1=0xFFFFFFFF and RD2=1 -> 1; ALUOp2=111 with the same operands -> 0.
REQ-036 The bench SHALL cover: WS=0 with WE=1 -> S3_WriteEnable=0 and retire_count unchanged.
REQ-037 The bench SHALL cover: stall held for 3 cycles while the inputs change -> outputs unchanged; stall+flush together -> S3_valid=0 and S3_WriteEnable=0 next cycle.
REQ-038 The bench SHALL cover: S3 holds WS=4 with WE=1; src1_sel=4, src2_sel=4 -> fwd_hit1=fwd_hit2=1 and fwd_data=S3_ALUOut; src1_sel=0 -> fwd_hit1=0.
REQ-039 The bench SHALL cover: with CNT_W=4, 16 retiring writes -> retire_count returns to 0; rst asserted alongside a valid write -> all outputs 0 and no count.
